// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS datapath: state encoding,
// opcodes, ALU operation codes and datapath mux select codes.
package mips_pkg;

  // Control FSM state encoding. Codes 12-15 are never used.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  // Supported opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // alu_op codes, shared with the ALU control unit.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU B input select codes.
  localparam logic [1:0] ALU_B_REG     = 2'b00;
  localparam logic [1:0] ALU_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

  // PC source select codes.
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // True for the two memory-referencing opcodes that share address calculation.
  function automatic logic is_mem_op(input logic [5:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_control_unit.sv
// Main control FSM for the multi-cycle MIPS datapath. The state register is
// the only storage; every datapath control is a combinational decode of the
// current state, with mem_ready gating only the fetch-stage load enables.
module multicycle_control_unit
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e state_q;
  state_e state_d;

  // State register; reset returns to FETCH immediately without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; every output defaults to 0 so unlisted
  // outputs (and the unreachable encodings) drive nothing.
  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALU_B_REG;
    alu_op        = ALU_OP_ADD;
    pc_source     = PC_SRC_ALU;
    illegal_op    = 1'b0;

    case (state_q)
      S_FETCH: begin
        // Read instruction at PC and compute PC+4; IR and PC load only once
        // the memory has delivered the word.
        mem_read  = 1'b1;
        i_or_d    = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = ALU_B_FOUR;
        alu_op    = ALU_OP_ADD;
        pc_source = PC_SRC_ALU;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_a = 1'b0;
        alu_src_b = ALU_B_IMM_SH2;
        alu_op    = ALU_OP_ADD;
        if (is_mem_op(op)) begin
          state_d = S_MEMADR;
        end else begin
          case (op)
            OP_RTYPE: state_d = S_EXEC;
            OP_BEQ:   state_d = S_BRANCH;
            OP_J:     state_d = S_JUMP;
            OP_ADDI:  state_d = S_ADDIEX;
            default: begin
              state_d    = S_FETCH;
              illegal_op = 1'b1;
            end
          endcase
        end
      end

      S_MEMADR: begin
        // Effective address = A + sign-extended immediate.
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
        alu_op    = ALU_OP_ADD;
        if (op == OP_LW) begin
          state_d = S_MEMRD;
        end else if (op == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_MEMRD: begin
        // Data read held until the memory completes.
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMRD;
        end
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        reg_dst    = 1'b0;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        // Data write held until the memory completes.
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWR;
        end
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_REG;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        mem_to_reg = 1'b0;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        // Compare A and B; PC takes the precomputed target if equal.
        alu_src_a     = 1'b1;
        alu_src_b     = ALU_B_REG;
        alu_op        = ALU_OP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PC_SRC_JUMP;
        state_d   = S_FETCH;
      end

      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
        alu_op    = ALU_OP_ADD;
        state_d   = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        state_d    = S_FETCH;
      end

      default: begin
        // Unreachable encodings recover to FETCH with all outputs idle.
        state_d = S_FETCH;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. Each cycle the expected
// state and control vector are pushed to a scoreboard when inputs are driven,
// then popped and compared on the falling edge.
module tb_multicycle_control_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [16:0] outs;
  } exp_t;

  exp_t sb_q[$];

  multicycle_control_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed control vector in a fixed field order.
  logic [16:0] obs_outs;
  assign obs_outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a,
                     alu_src_b, alu_op, pc_source, illegal_op};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference control table for each state, written out from the state list.
  function automatic logic [16:0] exp_out(input logic [3:0] s, input logic mr, input logic [5:0] o);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, ill;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, ill} = 11'b0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      4'd0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
      4'd1:  begin
               asb = 2'b11;
               ill = !(o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
                       o == 6'b000100 || o == 6'b000010 || o == 6'b001000);
             end
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  begin mrd = 1'b1; iod = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin mwr = 1'b1; iod = 1'b1; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rw = 1'b1; rd = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; end
      4'd9:  begin pw = 1'b1; psrc = 2'b10; end
      4'd10: begin asa = 1'b1; asb = 2'b10; end
      4'd11: begin rw = 1'b1; end
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
  endfunction

  // One clock cycle: drive inputs just after the rising edge, predict, then
  // check on the falling edge and step to just after the next rising edge.
  task automatic cycle(input string tag, input logic [5:0] op_v, input logic mr, input logic [3:0] exp_st);
    exp_t e;
    exp_t got;
    op        = op_v;
    mem_ready = mr;
    e.tag  = tag;
    e.st   = exp_st;
    e.outs = exp_out(exp_st, mr, op_v);
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      check_val({got.tag, "_state"}, {28'd0, state}, {28'd0, got.st});
      check_val({got.tag, "_outs"}, {15'd0, obs_outs}, {15'd0, got.outs});
    end
    @(posedge clk);
    #1;
  endtask

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst_n     = 1'b0;
    op        = 6'b000000;
    mem_ready = 1'b1;
    #2;
    // Reset state and FETCH decode during reset.
    check_val("rst_state", {28'd0, state}, 32'd0);
    check_val("rst_outs", {15'd0, obs_outs}, {15'd0, exp_out(4'd0, 1'b1, 6'd0)});
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // R-type, mem_ready ignored in EXEC.
    cycle("r_fetch",  6'b000000, 1'b1, 4'd0);
    cycle("r_decode", 6'b000000, 1'b1, 4'd1);
    cycle("r_exec",   6'b000000, 1'b0, 4'd6);
    cycle("r_aluwb",  6'b000000, 1'b1, 4'd7);

    // lw with two wait cycles in MEMRD.
    cycle("lw_fetch",  6'b100011, 1'b1, 4'd0);
    cycle("lw_decode", 6'b100011, 1'b1, 4'd1);
    cycle("lw_memadr", 6'b100011, 1'b0, 4'd2);
    cycle("lw_memrd0", 6'b100011, 1'b0, 4'd3);
    cycle("lw_memrd1", 6'b100011, 1'b0, 4'd3);
    cycle("lw_memrd2", 6'b100011, 1'b1, 4'd3);
    cycle("lw_memwb",  6'b100011, 1'b1, 4'd4);

    // sw with a wait in the first FETCH cycle.
    cycle("sw_fetch0", 6'b101011, 1'b0, 4'd0);
    cycle("sw_fetch1", 6'b101011, 1'b1, 4'd0);
    cycle("sw_decode", 6'b101011, 1'b1, 4'd1);
    cycle("sw_memadr", 6'b101011, 1'b1, 4'd2);
    cycle("sw_memwr",  6'b101011, 1'b1, 4'd5);

    // beq, j, addi back to back.
    cycle("beq_fetch",  6'b000100, 1'b1, 4'd0);
    cycle("beq_decode", 6'b000100, 1'b0, 4'd1);
    cycle("beq_branch", 6'b000100, 1'b1, 4'd8);
    cycle("j_fetch",    6'b000010, 1'b1, 4'd0);
    cycle("j_decode",   6'b000010, 1'b1, 4'd1);
    cycle("j_jump",     6'b000010, 1'b0, 4'd9);
    cycle("addi_fetch", 6'b001000, 1'b1, 4'd0);
    cycle("addi_decode",6'b001000, 1'b1, 4'd1);
    cycle("addi_ex",    6'b001000, 1'b1, 4'd10);
    cycle("addi_wb",    6'b001000, 1'b1, 4'd11);

    // Illegal opcode: one-cycle pulse in DECODE, then back to FETCH.
    cycle("ill_fetch",  6'b111111, 1'b1, 4'd0);
    cycle("ill_decode", 6'b111111, 1'b1, 4'd1);
    cycle("ill_after",  6'b111111, 1'b0, 4'd0);
    cycle("ill_hold",   6'b111111, 1'b1, 4'd0);

    // Reset asserted while a store is waiting in MEMWR.
    cycle("rs_decode", 6'b101011, 1'b1, 4'd1);
    cycle("rs_memadr", 6'b101011, 1'b1, 4'd2);
    cycle("rs_memwr",  6'b101011, 1'b0, 4'd5);
    check_val("rs_mw_before", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rs_state_async", {28'd0, state}, 32'd0);
    check_val("rs_mem_write", {31'd0, mem_write}, 32'd0);
    check_val("rs_reg_write", {31'd0, reg_write}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle("rs_fetch", 6'b101011, 1'b0, 4'd0);
    cycle("rs_fetch_go", 6'b101011, 1'b1, 4'd0);
    cycle("rs_decode2", 6'b101011, 1'b1, 4'd1);

    check_val("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
